// File: rtl/dmac_pkg.sv
// Shared types and constants for the single-channel DMA copy engine.
// Imported by the engine top and its staging FIFO.
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RREQ,
        RDATA,
        WREQ,
        WDATA,
        WRESP,
        DONE
    } dmac_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AxSIZE encodes log2 of the number of bytes carried by one beat.
    function automatic logic [2:0] axsize_of(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dmac_fifo.sv
// Synchronous first-word-fall-through FIFO that stages one burst of read data
// before it is replayed on the write channel.
module dmac_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/dmac_engine.sv
// Single-channel DMA copy engine: moves byte_len bytes from src to dst as
// alternating AXI read/write bursts, staging each burst in a local FIFO.
module dmac_engine
    import dmac_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ID     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [ADDR_WIDTH-1:0]        src_addr_i,
    input  logic [ADDR_WIDTH-1:0]        dst_addr_i,
    input  logic [15:0]                  byte_len_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ADDR_WIDTH-1:0]        awaddr,
    output logic [ID_WIDTH-1:0]          awid,
    output logic [$clog2(MAX_BURST)-1:0] awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic                         wlast,
    output logic [ID_WIDTH-1:0]          wid,
    input  logic                         bvalid,
    output logic                         bready,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [ADDR_WIDTH-1:0]        araddr,
    output logic [ID_WIDTH-1:0]          arid,
    output logic [$clog2(MAX_BURST)-1:0] arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rlast
);

    localparam int         BPB    = DATA_WIDTH / 8;
    localparam int         LEN_W  = $clog2(MAX_BURST);
    localparam int         BLEN_W = LEN_W + 1;
    localparam logic [2:0] AXSIZE = axsize_of(DATA_WIDTH);

    dmac_state_e           state;
    dmac_state_e           next_state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [15:0]           rem_beats;
    logic [15:0]           start_beats;
    logic [BLEN_W-1:0]     blen;
    logic [BLEN_W-1:0]     beat_cnt;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    // rem_beats is frozen from RREQ through WRESP, so blen is stable for a whole pair.
    assign start_beats = byte_len_i >> AXSIZE;
    assign blen        = (rem_beats >= 16'(MAX_BURST)) ? BLEN_W'(MAX_BURST)
                                                       : rem_beats[BLEN_W-1:0];
    assign burst_bytes = ADDR_WIDTH'(blen) << AXSIZE;

    assign araddr  = src_q;
    assign arlen   = LEN_W'(blen - 1'b1);
    assign arsize  = AXSIZE;
    assign arburst = AXI_BURST_INCR;
    assign arid    = ID_WIDTH'(AXI_ID);
    assign awaddr  = dst_q;
    assign awlen   = LEN_W'(blen - 1'b1);
    assign awsize  = AXSIZE;
    assign awburst = AXI_BURST_INCR;
    assign awid    = ID_WIDTH'(AXI_ID);
    assign wid     = ID_WIDTH'(AXI_ID);
    assign wdata   = fifo_rdata;
    assign wstrb   = '1;
    assign wlast   = (beat_cnt == blen - 1'b1);

    dmac_fifo #(
        .DEPTH(MAX_BURST),
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (r_hs),
        .wdata(rdata),
        .pop  (w_hs),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero-length request skips the bus entirely and just reports completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = (start_beats == '0) ? DONE : RREQ;
            RREQ:    if (ar_hs) next_state = RDATA;
            RDATA:   if (r_hs && rlast) next_state = WREQ;
            WREQ:    if (aw_hs) next_state = WDATA;
            WDATA:   if (w_hs && wlast) next_state = WRESP;
            WRESP:   if (b_hs) next_state = (rem_beats == 16'(blen)) ? DONE : RREQ;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state)
            IDLE:    busy_o  = 1'b0;
            RREQ:    arvalid = 1'b1;
            RDATA:   rready  = !fifo_full;
            WREQ:    awvalid = 1'b1;
            WDATA:   wvalid  = !fifo_empty;
            WRESP:   bready  = 1'b1;
            DONE:    done_o  = 1'b1;
            default: busy_o  = 1'b1;
        endcase
    end

    // Addresses only advance once the write response confirms the burst landed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q     <= '0;
            dst_q     <= '0;
            rem_beats <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_q     <= src_addr_i;
                        dst_q     <= dst_addr_i;
                        rem_beats <= start_beats;
                    end
                end
                WREQ: beat_cnt <= '0;
                WDATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        src_q     <= src_q + burst_bytes;
                        dst_q     <= dst_q + burst_bytes;
                        rem_beats <= rem_beats - 16'(blen);
                    end
                end
                default: beat_cnt <= beat_cnt;
            endcase
        end
    end

    a_aligned_request: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && start_i) |->
            ((src_addr_i % ADDR_WIDTH'(BPB)) == '0 &&
             (dst_addr_i % ADDR_WIDTH'(BPB)) == '0 &&
             (byte_len_i % 16'(BPB)) == '0));

endmodule

// File: tb/tb_dmac_engine.sv
// Bench for dmac_engine: an AXI slave memory model plus a burst/data reference
// model, directed copy scenarios followed by randomized copies with stalls.
`timescale 1ns/1ps
module tb_dmac_engine;

    localparam int AW        = 16;
    localparam int DW        = 32;
    localparam int IDW       = 4;
    localparam int MEM_WORDS = 1 << (AW - 2);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i;
    logic [AW-1:0]   src_addr_i;
    logic [AW-1:0]   dst_addr_i;
    logic [15:0]     byte_len_i;
    logic            busy_o;
    logic            done_o;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0]   awaddr, araddr;
    logic [IDW-1:0]  awid, arid, wid;
    logic [3:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    always #5 clk = ~clk;

    dmac_engine #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IDW),
        .MAX_BURST (16),
        .AXI_ID    (0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MEM_WORDS];

    // Reference model: expected bursts, expected write beats, expected dst image.
    logic [15:0] exp_ar_addr[$], exp_aw_addr[$];
    logic [3:0]  exp_ar_len[$], exp_aw_len[$];
    logic [31:0] exp_w[$], exp_copy[$];
    logic [15:0] copy_dst;

    logic [15:0] obs_ar_addr[$], obs_aw_addr[$];
    logic [3:0]  obs_ar_len[$], obs_aw_len[$];
    int          obs_w_cnt, obs_wlast_beat, done_count;

    int ar_delay, aw_delay, r_delay;
    bit rand_stall;

    // Slave-side state
    bit          rd_active, wr_active, b_pending, r_hold, prev_done;
    logic [15:0] rd_addr, wr_addr;
    int          rd_left, wr_left, rd_wait, b_wait, ar_cnt, aw_cnt;
    bit          ar_stall, aw_stall, w_stall;
    logic [15:0] hold_araddr, hold_awaddr;
    logic [3:0]  hold_arlen, hold_awlen;
    logic [31:0] hold_wdata;
    logic        hold_wlast;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit coin();
        return rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    endfunction

    // AXI slave memory model and per-cycle protocol/data compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            rd_active = 0; wr_active = 0; b_pending = 0; r_hold = 0;
            rd_addr = '0; wr_addr = '0; rd_left = 0; wr_left = 0;
            rd_wait = 0; b_wait = 0; ar_cnt = 0; aw_cnt = 0;
            ar_stall = 0; aw_stall = 0; w_stall = 0; prev_done = 0;
        end else begin
            if (ar_stall)
                check_output("ar_hold", 32'({arvalid, arlen, araddr}), 32'({1'b1, hold_arlen, hold_araddr}));
            if (aw_stall)
                check_output("aw_hold", 32'({awvalid, awlen, awaddr}), 32'({1'b1, hold_awlen, hold_awaddr}));
            if (w_stall) begin
                check_output("w_hold_data", wdata, hold_wdata);
                check_output("w_hold_ctl", 32'({wvalid, wlast}), 32'({1'b1, hold_wlast}));
            end
            if (awvalid && !aw_stall)
                check_output("aw_after_read", 32'(rd_active), 32'd0);

            arready = arvalid && !rd_active && (ar_cnt >= ar_delay) && coin();
            if (!rd_active) begin
                rvalid = 1'b0;
            end else if (!r_hold) begin
                if (rd_wait > 0) begin
                    rd_wait--;
                    rvalid = 1'b0;
                end else begin
                    rvalid = coin();
                end
            end
            rdata   = mem[rd_addr[15:2]];
            rlast   = (rd_left == 1);
            awready = awvalid && !wr_active && !b_pending && (aw_cnt >= aw_delay) && coin();
            wready  = wr_active && coin();
            if (b_pending && b_wait > 0) begin
                b_wait--;
                bvalid = 1'b0;
            end else begin
                bvalid = b_pending;
            end

            if (rvalid && rready) begin
                rd_addr += 16'd4;
                rd_left--;
                if (rd_left == 0) rd_active = 0;
            end
            r_hold = rvalid && !rready;

            if (arvalid && arready) begin
                check_output("ar_no_write_pending", 32'({wr_active, b_pending}), 32'd0);
                check_output("ar_expected", 32'(exp_ar_addr.size() > 0), 32'd1);
                if (exp_ar_addr.size() > 0) begin
                    check_output("ar_addr", 32'(araddr), 32'(exp_ar_addr.pop_front()));
                    check_output("ar_len", 32'(arlen), 32'(exp_ar_len.pop_front()));
                end
                check_output("ar_fixed", 32'({arsize, arburst, arid}), 32'({3'd2, 2'b01, 4'd0}));
                obs_ar_addr.push_back(araddr);
                obs_ar_len.push_back(arlen);
                rd_active = 1; rd_addr = araddr; rd_left = int'(arlen) + 1;
                rd_wait = r_delay; ar_cnt = 0;
            end else if (arvalid) begin
                ar_cnt++;
            end

            if (wvalid && wready) begin
                obs_w_cnt++;
                check_output("w_expected", 32'(exp_w.size() > 0), 32'd1);
                if (exp_w.size() > 0)
                    check_output("w_data", wdata, exp_w.pop_front());
                check_output("w_last", 32'(wlast), 32'(wr_left == 1));
                check_output("w_strb", 32'(wstrb), 32'hF);
                if (wlast) obs_wlast_beat = obs_w_cnt;
                mem[wr_addr[15:2]] = wdata;
                wr_addr += 16'd4;
                wr_left--;
                if (wr_left == 0) begin
                    wr_active = 0;
                    b_pending = 1;
                    b_wait = rand_stall ? int'($urandom_range(0, 3)) : 0;
                end
            end

            if (bvalid && bready) b_pending = 0;

            if (awvalid && awready) begin
                check_output("aw_expected", 32'(exp_aw_addr.size() > 0), 32'd1);
                if (exp_aw_addr.size() > 0) begin
                    check_output("aw_addr", 32'(awaddr), 32'(exp_aw_addr.pop_front()));
                    check_output("aw_len", 32'(awlen), 32'(exp_aw_len.pop_front()));
                end
                check_output("aw_fixed", 32'({awsize, awburst, awid, wid}), 32'({3'd2, 2'b01, 4'd0, 4'd0}));
                obs_aw_addr.push_back(awaddr);
                obs_aw_len.push_back(awlen);
                wr_active = 1; wr_addr = awaddr; wr_left = int'(awlen) + 1; aw_cnt = 0;
            end else if (awvalid) begin
                aw_cnt++;
            end

            if (done_o) begin
                check_output("done_single", 32'(prev_done), 32'd0);
                check_output("busy_at_done", 32'(busy_o), 32'd1);
                done_count++;
            end
            prev_done = done_o;

            ar_stall = arvalid && !arready; hold_araddr = araddr; hold_arlen = arlen;
            aw_stall = awvalid && !awready; hold_awaddr = awaddr; hold_awlen = awlen;
            w_stall  = wvalid && !wready;   hold_wdata  = wdata;  hold_wlast = wlast;
        end
    end

    task automatic build_model(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        int rem, b;
        logic [15:0] a, d;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        exp_w.delete(); exp_copy.delete();
        obs_ar_addr.delete(); obs_ar_len.delete(); obs_aw_addr.delete(); obs_aw_len.delete();
        obs_w_cnt = 0; obs_wlast_beat = 0;
        copy_dst = dst;
        for (int i = 0; i < int'(len) / 4; i++) begin
            exp_w.push_back(mem[(int'(src) / 4 + i) % MEM_WORDS]);
            exp_copy.push_back(mem[(int'(src) / 4 + i) % MEM_WORDS]);
        end
        rem = int'(len) / 4; a = src; d = dst;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            exp_ar_addr.push_back(a); exp_ar_len.push_back(4'(b - 1));
            exp_aw_addr.push_back(d); exp_aw_len.push_back(4'(b - 1));
            a += 16'(b * 4); d += 16'(b * 4); rem -= b;
        end
    endtask

    task automatic pulse_start(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        @(posedge clk); #1;
        src_addr_i = src; dst_addr_i = dst; byte_len_i = len; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (done_o) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check_output("done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check_output("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    task automatic verify_copy();
        int bad = 0;
        foreach (exp_copy[i])
            if (mem[(int'(copy_dst) / 4 + i) % MEM_WORDS] !== exp_copy[i]) bad++;
        check_output("dst_data_words_wrong", 32'(bad), 32'd0);
        check_output("bursts_left", 32'(exp_ar_addr.size() + exp_aw_addr.size() + exp_w.size()), 32'd0);
    endtask

    task automatic apply_stimulus(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        int d0;
        build_model(src, dst, len);
        d0 = done_count;
        pulse_start(src, dst, len);
        wait_done();
        verify_copy();
        check_output("done_pulses", 32'(done_count - d0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        logic [31:0] snap;
        start_i = 0; src_addr_i = '0; dst_addr_i = '0; byte_len_i = '0;
        ar_delay = 0; aw_delay = 0; r_delay = 0; rand_stall = 0; done_count = 0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        for (int k = 0; k < 64; k++)
            mem[k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};

        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_outputs",
                     32'({busy_o, done_o, arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        rst_n = 1;

        apply_stimulus(16'h0000, 16'h1000, 16'd64);
        check_output("t1_ar_count", 32'(obs_ar_addr.size()), 32'd1);
        check_output("t1_aw_count", 32'(obs_aw_addr.size()), 32'd1);
        if (obs_ar_addr.size() > 0) begin
            check_output("t1_araddr", 32'(obs_ar_addr[0]), 32'h0000);
            check_output("t1_arlen", 32'(obs_ar_len[0]), 32'd15);
        end
        if (obs_aw_addr.size() > 0) begin
            check_output("t1_awaddr", 32'(obs_aw_addr[0]), 32'h1000);
            check_output("t1_awlen", 32'(obs_aw_len[0]), 32'd15);
        end
        check_output("t1_w_beats", 32'(obs_w_cnt), 32'd16);
        check_output("t1_wlast_beat", 32'(obs_wlast_beat), 32'd16);
        check_output("t1_mem_1000", mem[16'h1000 >> 2], 32'h03020100);
        check_output("t1_mem_103c", mem[16'h103C >> 2], 32'h3F3E3D3C);

        apply_stimulus(16'h0000, 16'h1000, 16'd72);
        check_output("t2_ar_count", 32'(obs_ar_addr.size()), 32'd2);
        if (obs_ar_addr.size() > 1 && obs_aw_addr.size() > 1) begin
            check_output("t2_arlen0", 32'(obs_ar_len[0]), 32'd15);
            check_output("t2_arlen1", 32'(obs_ar_len[1]), 32'd1);
            check_output("t2_araddr1", 32'(obs_ar_addr[1]), 32'h0040);
            check_output("t2_awaddr1", 32'(obs_aw_addr[1]), 32'h1040);
            check_output("t2_awlen1", 32'(obs_aw_len[1]), 32'd1);
        end
        check_output("t2_mem_1044", mem[16'h1044 >> 2], 32'h47464544);

        build_model(16'h0100, 16'h2000, 16'd0);
        d0 = done_count;
        pulse_start(16'h0100, 16'h2000, 16'd0);
        check_output("t3_done_next_cycle", 32'(done_o), 32'd1);
        @(posedge clk); #1;
        check_output("t3_done_cleared", 32'({done_o, busy_o}), 32'd0);
        check_output("t3_no_bursts", 32'(obs_ar_addr.size() + obs_aw_addr.size()), 32'd0);
        check_output("t3_done_pulses", 32'(done_count - d0), 32'd1);

        snap = mem[16'h3400 >> 2];
        build_model(16'h0000, 16'h3000, 16'd16);
        d0 = done_count;
        pulse_start(16'h0000, 16'h3000, 16'd16);
        repeat (3) @(posedge clk);
        pulse_start(16'h0080, 16'h3400, 16'd16);
        wait_done();
        verify_copy();
        repeat (60) @(posedge clk);
        #1;
        check_output("t4_done_pulses", 32'(done_count - d0), 32'd1);
        check_output("t4_ar_count", 32'(obs_ar_addr.size()), 32'd1);
        check_output("t4_second_dst_untouched", mem[16'h3400 >> 2], snap);

        ar_delay = 3; aw_delay = 5; r_delay = 20;
        apply_stimulus(16'h0000, 16'h1800, 16'd72);
        ar_delay = 0; aw_delay = 0; r_delay = 0;

        build_model(16'h0000, 16'h4000, 16'd64);
        pulse_start(16'h0000, 16'h4000, 16'd64);
        begin
            bit reached = 0;
            for (int c = 0; c < 500 && !reached; c++) begin
                @(posedge clk); #1;
                if (obs_w_cnt >= 3) reached = 1;
            end
            check_output("t6_reached_wdata", 32'(reached), 32'd1);
        end
        rst_n = 0;
        @(posedge clk); #1;
        check_output("t6_idle_after_reset",
                     32'({busy_o, done_o, arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        rst_n = 1;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        exp_w.delete();
        apply_stimulus(16'h0010, 16'h5000, 16'd8);
        check_output("t6_mem_5000", mem[16'h5000 >> 2], 32'h13121110);
        check_output("t6_mem_5004", mem[16'h5004 >> 2], 32'h17161514);

        rand_stall = 1;
        for (int n = 0; n < 12; n++) begin
            ar_delay = int'($urandom_range(0, 3));
            aw_delay = int'($urandom_range(0, 3));
            r_delay  = int'($urandom_range(0, 4));
            apply_stimulus(16'h2000 + 16'(4 * $urandom_range(0, 255)),
                           16'h8000 + 16'(4 * $urandom_range(0, 511)),
                           16'(4 * $urandom_range(0, 70)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
